bcd_to_binary: RTL and testbench

Sequential reverse double-dabble converter: accepts four BCD digits (thousands..ones, as produced for the seven-segment path) and returns their 14-bit binary value. Sits on the input side of the display datapath, e.g. behind keypad/digit-entry logic, so decimal values entered by the user can be used arithmetically. Uses a start/busy/done handshake and one shift per cycle.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_nibble_adjust.sv | 10 +
 rtl/bcd_to_binary.sv | 142 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared widths, shift count and state encoding for the BCD-to-binary converter.
package bcd_pkg;

  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;
  localparam int BIN_W     = 14;
  localparam int SHIFT_CNT = 14;

  localparam logic [3:0] LAST_SHIFT = 4'(SHIFT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True when any BCD nibble holds a non-decimal code (A..F).
  function automatic logic digit_over(input logic [BCD_W-1:0] bcd);
    logic over;
    over = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) over = 1'b1;
    end
    return over;
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
module bcd_nibble_adjust (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // A set bit 3 arrived from the next-higher decade: it weighs 5, not 8.
  assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: four BCD digits in, 14-bit binary out.
// Digit range checking is built only when BCD_TO_BINARY_CHECK_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; digits captured on the accepting edge
// ST_SHIFT | one shift + nibble adjust per cycle, 14 shifts in total
// ST_DONE  | result published, done high for this single cycle
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   work_q, work_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   work_sh;

  assign {bcd_sh, work_sh} = {bcd_q, work_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib_in  (bcd_sh[4*g +: 4]),
      .nib_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD_TO_BINARY_CHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_TO_BINARY_CHECK_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d   = {bcd3, bcd2, bcd1, bcd0};
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef BCD_TO_BINARY_CHECK_EN
          flag_d  = digit_over({bcd3, bcd2, bcd1, bcd0});
`endif
        end
      end
      ST_SHIFT: begin
        bcd_d  = bcd_adj;
        work_d = work_sh;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
`ifdef BCD_TO_BINARY_CHECK_EN
          bin_d   = flag_q ? '0 : work_sh;
          err_d   = flag_q;
`else
          bin_d   = work_sh;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_TO_BINARY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results, a negedge monitor pops on done.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
  logic [13:0] bin;
  logic        busy, done, err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    logic        chk_bin;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  bcd_to_binary dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd3  (bcd3),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && done) begin
      check("done_width", done_prev, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        if (e.chk_bin) check("bin", bin, e.bin);
        check("err", err, e.err);
      end
    end
    done_prev = done;
  end

  // Called at a negedge with the DUT idle; acceptance is the next posedge,
  // done is visible 14 edges later, i.e. at the negedge where cyc = now + 15.
  task automatic issue(input logic [3:0] d3, d2, d1, d0,
                       input logic [13:0] eb, input logic ee,
                       input logic cb, input logic push);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
    start = 1'b1;
    if (push) sb.push_back('{eb, ee, cb, cyc + 15});
  endtask

  task automatic finish_conv(input logic [13:0] eb, input logic cb);
    @(negedge clk);
    start = 1'b0;
    check("busy_mid", busy, 1);
    repeat (14) begin
      @(negedge clk);
      check("busy_mid", busy, 1);
    end
    @(negedge clk);
    check("busy_end", busy, 0);
    if (cb) check("bin_hold", bin, eb);
  endtask

  task automatic run_conv(input logic [3:0] d3, d2, d1, d0,
                          input logic [13:0] eb, input logic ee, input logic cb);
    issue(d3, d2, d1, d0, eb, ee, cb, 1'b1);
    finish_conv(eb, cb);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bin", bin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic vectors, issued back-to-back right after each done falls.
    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0, 1'b1);
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0, 1'b1);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0, 1'b1);

    // Inputs change and start pulses after acceptance: only 3000 is converted.
    issue(4'd3, 4'd0, 4'd0, 4'd0, 14'd3000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_pulse", busy, 1);
    repeat (10) @(negedge clk);
    check("busy_end", busy, 0);
    check("bin_hold", bin, 3000);
    @(negedge clk);
    check("no_requeue", busy, 0);

    // Start held high across two conversions, digits changed mid-flight.
    issue(4'd2, 4'd0, 4'd2, 4'd4, 14'd2024, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bcd3 = 4'd0; bcd2 = 4'd8; bcd1 = 4'd0; bcd0 = 4'd5;
    check("busy_held", busy, 1);
    repeat (14) begin
      @(negedge clk);
      check("busy_held", busy, 1);
    end
    @(negedge clk);
    check("busy_gap", busy, 0);
    check("bin_held", bin, 2024);
    issue(4'd0, 4'd8, 4'd0, 4'd5, 14'd805, 1'b0, 1'b1, 1'b1);
    finish_conv(14'd805, 1'b1);

    // Out-of-range digit, then a clean conversion.
`ifdef BCD_TO_BINARY_CHECK_EN
    run_conv(4'd1, 4'hA, 4'd0, 4'd5, 14'd0, 1'b1, 1'b1);
`else
    run_conv(4'd1, 4'hA, 4'd0, 4'd5, 14'd0, 1'b0, 1'b0);
`endif
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0, 1'b1);

    // Reset after the 7th shift of 5678: everything clears, no done.
    issue(4'd5, 4'd6, 4'd7, 4'd8, 14'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_bin", bin, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_bin", bin, 0);
    run_conv(4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
